// File: rtl/reverb_param_pkg.sv
// Shared types and default sizing for the reverb parameter scheduler.
package reverb_param_pkg;
    localparam int              NUM_PARAMS_DEF = 16;
    localparam int              PARAM_TYPE_W   = 4;
    localparam int              DATA_W_DEF     = 16;
    localparam logic [15:0]     STEP_DEF       = 16'h0100;

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_e;
    typedef enum logic {REQ_HOST = 1'b0, REQ_PANEL = 1'b1} req_id_e;
endpackage

// File: rtl/reverb_param_scheduler_if.sv
// Request/acknowledge bus for the two parameter update requesters (host and panel).
interface reverb_param_scheduler_if
    import reverb_param_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                    host_req;
    logic [PARAM_TYPE_W-1:0] host_type;
    logic [DATA_W-1:0]       host_value;
    logic                    host_ack;
    logic                    panel_req;
    logic [PARAM_TYPE_W-1:0] panel_type;
    logic [DATA_W-1:0]       panel_value;
    logic                    panel_ack;

    modport master (
        output host_req, host_type, host_value, panel_req, panel_type, panel_value,
        input  host_ack, panel_ack
    );
    modport slave (
        input  host_req, host_type, host_value, panel_req, panel_type, panel_value,
        output host_ack, panel_ack
    );
endinterface

// File: rtl/reverb_param_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module reverb_param_rr_arb
    import reverb_param_pkg::*;
(
    input  logic       host_req,
    input  logic       panel_req,
    input  req_id_e    last_grant,
    output logic [1:0] grant      // bit 0 host, bit 1 panel
);
    always_comb begin
        grant = 2'b00;
        if (host_req && panel_req) begin
            grant = (last_grant == REQ_PANEL) ? 2'b01 : 2'b10;
        end else if (host_req) begin
            grant = 2'b01;
        end else if (panel_req) begin
            grant = 2'b10;
        end
    end
endmodule

// File: rtl/reverb_param_scheduler.sv
// Arbitrates host/panel parameter updates and slews the selected register toward its
// target by at most STEP per sample tick, keeping the parameter bank free of zipper noise.
module reverb_param_scheduler
    import reverb_param_pkg::*;
#(
    parameter int              NUM_PARAMS = NUM_PARAMS_DEF,
    parameter int              DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] STEP     = STEP_DEF
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    reverb_param_scheduler_if.slave      bus,
    output logic                         param_we,
    output logic [PARAM_TYPE_W-1:0]      param_addr,
    output logic [DATA_W-1:0]            param_wdata,
    output logic [NUM_PARAMS*DATA_W-1:0] params_flat,
    output logic [PARAM_TYPE_W-1:0]      active_type,
    output logic                         busy,
    output logic                         update_done,
    output logic                         type_err
);
    state_e                  state_q, state_d;
    req_id_e                 last_grant_q;
    logic [DATA_W-1:0]       params_q [NUM_PARAMS];
    logic [PARAM_TYPE_W-1:0] active_type_q;
    logic [DATA_W-1:0]       target_q;
    logic                    err_q;
    logic [1:0]              grant;
    logic                    xfer;
    logic [PARAM_TYPE_W-1:0] sel_type;
    logic [DATA_W-1:0]       sel_value;
    logic                    sel_err;
    logic                    sel_same;
    logic [DATA_W-1:0]       cur_val;
    logic [DATA_W-1:0]       next_val;

    function automatic logic type_valid(input logic [PARAM_TYPE_W-1:0] t);
        return int'(t) < NUM_PARAMS;
    endfunction

    function automatic logic [DATA_W-1:0] rd_param(input logic [PARAM_TYPE_W-1:0] t);
        return type_valid(t) ? params_q[t] : '0;
    endfunction

    // Step toward tgt; the distance check rules out any wrap of cur +/- STEP.
    function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] cur,
                                               input logic [DATA_W-1:0] tgt);
        if (tgt > cur) begin
            return (tgt - cur <= STEP) ? tgt : cur + STEP;
        end
        return (cur - tgt <= STEP) ? tgt : cur - STEP;
    endfunction

    reverb_param_rr_arb u_arb (
        .host_req   (bus.host_req),
        .panel_req  (bus.panel_req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Acks are withheld while reset is asserted so nothing is accepted on a reset edge.
    assign bus.host_ack  = !reset && (state_q == IDLE) && grant[0];
    assign bus.panel_ack = !reset && (state_q == IDLE) && grant[1];
    assign xfer          = bus.host_ack || bus.panel_ack;

    assign sel_type  = bus.panel_ack ? bus.panel_type  : bus.host_type;
    assign sel_value = bus.panel_ack ? bus.panel_value : bus.host_value;
    assign sel_err   = !type_valid(sel_type);
    assign sel_same  = (rd_param(sel_type) == sel_value);
    assign cur_val   = rd_param(active_type_q);
    assign next_val  = slew(cur_val, target_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = (sel_err || sel_same) ? DONE : RAMP;
            RAMP:    if (sample_tick && (next_val == target_q)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q  <= REQ_PANEL;
            active_type_q <= '0;
            target_q      <= '0;
            err_q         <= 1'b0;
            param_we      <= 1'b0;
            param_addr    <= '0;
            param_wdata   <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) params_q[i] <= '0;
        end else begin
            param_we <= 1'b0;
            if (xfer) begin
                last_grant_q  <= bus.panel_ack ? REQ_PANEL : REQ_HOST;
                active_type_q <= sel_type;
                target_q      <= sel_value;
                err_q         <= sel_err;
            end
            // Only RAMP steps, so a tick on the transfer edge is naturally ignored.
            if ((state_q == RAMP) && sample_tick) begin
                params_q[active_type_q] <= next_val;
                param_we                <= 1'b1;
                param_addr              <= active_type_q;
                param_wdata             <= next_val;
            end
        end
    end

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_flat
        assign params_flat[g*DATA_W +: DATA_W] = params_q[g];
    end

    assign active_type = active_type_q;
    assign busy        = (state_q != IDLE);
    assign update_done = (state_q == DONE);
    assign type_err    = (state_q == DONE) && err_q;
endmodule

// File: doc/reverb_param_scheduler.md
Name: reverb_param_scheduler

Overview:
- Shares the reverb parameter register bank between two update requesters: the Nios host and a front-panel encoder interface.
- Round-robin arbitrates between them and slews the selected parameter toward its target by at most STEP per audio sample tick, avoiding zipper noise.
- Publishes the active parameter type, which feeds the 4-bit paramType PIO so software can read back which parameter is moving.

Parameters:
- NUM_PARAMS, 16: number of parameter registers; type field is 4 bits.
- DATA_W, 16: unsigned parameter width.
- STEP, 16'h0100: maximum change per sample_tick.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse per audio sample.
- host_req  in  1  host request valid; held until host_ack.
- host_type  in  4  host parameter index.
- host_value  in  DATA_W  host target value.
- host_ack  out  1  host request accepted this cycle.
- panel_req  in  1  panel request valid; held until panel_ack.
- panel_type  in  4  panel parameter index.
- panel_value  in  DATA_W  panel target value.
- panel_ack  out  1  panel request accepted this cycle.
- param_we  out  1  one-cycle write strobe to the parameter bank.
- param_addr  out  4  index written.
- param_wdata  out  DATA_W  value written.
- params_flat  out  NUM_PARAMS*DATA_W  all current values; index i at bits [i*DATA_W +: DATA_W].
- active_type  out  4  index being ramped; to paramType PIO in_port.
- busy  out  1  state != IDLE.
- update_done  out  1  one-cycle pulse when a request completes.
- type_err  out  1  one-cycle pulse with update_done if the type was invalid.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, every param reg=0, active_type=0, last_grant=panel (host wins the first tie), all strobes/acks=0. A reset mid-ramp abandons the ramp and returns all params to 0.
- Acceptance: acks are combinational. ack_x = (state==IDLE) && grant_x. A transfer occurs on a clk edge where req_x && ack_x.
- Arbitration in IDLE: only one req asserted → grant it. Both asserted → grant the requester not equal to last_grant. last_grant updates on each transfer.
- On transfer: latch type into active_type and value into target.
  - type >= NUM_PARAMS → DONE with err flag; no param change.
  - params[type]==target → DONE.
  - otherwise → RAMP.
- RAMP: each cycle with sample_tick=1:
  - diff = |target - cur|.
  - diff <= STEP → cur=target; next state DONE.
  - otherwise cur = cur ± STEP toward target.
  - The same edge drives param_we=1, param_addr=active_type, param_wdata=new value; params_flat reflects the new value in the same registered cycle.
  - Cycles without a tick hold state.
- Arithmetic: unsigned DATA_W; ± never wraps because diff > STEP guarantees no under/overflow.
- A sample_tick that coincides with the transfer edge is ignored; the first step uses the next tick.
- DONE: exactly one cycle. update_done=1; type_err=1 if the err flag is set. Then → IDLE. No acks are issued in DONE, so a requester still holding req is accepted in the following IDLE cycle at the earliest.
- Requests arriving during RAMP/DONE wait with req held; no ack and no loss.
- The active_type output holds its last value after completion.
- busy = (state != IDLE).

Decomposition:
- Package reverb_param_pkg: NUM_PARAMS, PARAM_TYPE_W=4, DATA_W, STEP defaults, state enum {IDLE, RAMP, DONE}, requester id enum {REQ_HOST, REQ_PANEL}.
- One sub-module, reverb_param_rr_arb: 2-way round-robin arbiter (reqs, last_grant in; one-hot grant out). The FSM, slew logic and register bank stay in the top module.

Test Plan:
- Reset → all params 0, busy=0, acks only when req asserted in IDLE.
- Host requests type 3, value 0x0250, with ticks every 8 clks → param_we writes 0x0100, 0x0200, 0x0250 on successive ticks; then update_done pulse, busy drops next cycle.
- Host (type 1, 0x0100) and panel (type 2, 0x0080) both asserted in IDLE from reset → host acked first. After DONE → panel acked. Next tie → host acked again.
- Host requests type 5 with value equal to its current 0 → ack, then update_done the next cycle, zero param_we, no tick needed.
- Type 4'hF with NUM_PARAMS=12 → ack, then update_done+type_err; params_flat unchanged.
- Ramp type 0 from 0 to 0x0800, assert reset after 3 steps (value 0x0300) → all params 0, state IDLE; panel_req held during the ramp is accepted only after reset deasserts.
